// File: rtl/alu_serial.sv
// Multi-cycle ALU: WIDTH-bit add/sub/and/or evaluated CHUNK bits per cycle, carry held between chunks.
// Valid/ready on both sides; o and flags are registered when the last chunk completes.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one chunk per cycle, N cycles total
// DONE  | out_valid=1, result held until out_ready
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             last_chunk;
    logic             is_arith;
    logic [CHUNK-1:0] a_ch, b_ch, b_eff, r_ch;
    logic [CHUNK:0]   sum;
    logic             c_msb_in;

    assign last_chunk = (idx_q == IW'(N - 1));
    assign is_arith   = ~op_q[1];
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    // Operands shift right one chunk per cycle; the result fills in from the top.
    always_comb begin
        a_ch     = a_q[CHUNK-1:0];
        b_ch     = b_q[CHUNK-1:0];
        b_eff    = (op_q == OP_SUB) ? ~b_ch : b_ch;
        sum      = {1'b0, a_ch} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
        case (op_q)
            OP_AND:  r_ch = a_ch & b_ch;
            OP_OR:   r_ch = a_ch | b_ch;
            default: r_ch = sum[CHUNK-1:0];
        endcase
        c_msb_in = a_ch[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
        acc_nxt  = (acc_q >> CHUNK) | (WIDTH'(r_ch) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            o       <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q    <= op;
                    a_q     <= i0;
                    b_q     <= i1;
                    idx_q   <= '0;
                    carry_q <= (op == OP_SUB);
                end
                RUN: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    acc_q <= acc_nxt;
                    idx_q <= idx_q + 1'b1;
                    if (is_arith) carry_q <= sum[CHUNK];
                    if (last_chunk) begin
                        idx_q <= '0;
                        o     <= acc_nxt;
                        zero  <= (acc_nxt == '0);
                        neg   <= acc_nxt[WIDTH-1];
                        cout  <= is_arith & sum[CHUNK];
                        ovf   <= is_arith & (c_msb_in ^ sum[CHUNK]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (CHUNK 4, 16, 1) checked against an arithmetic reference model.
module tb_alu_serial;
    localparam int LAT [3] = '{4, 1, 16};

    logic        clk = 1'b0;
    logic        reset     [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [1:0]  op        [3];
    logic [15:0] i0        [3];
    logic [15:0] i1        [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] o         [3];
    logic        cout      [3];
    logic        zero      [3];
    logic        neg       [3];
    logic        ovf       [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .i0(i0[0]), .i1(i1[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .o(o[0]), .cout(cout[0]), .zero(zero[0]), .neg(neg[0]), .ovf(ovf[0]));
    alu_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .i0(i0[1]), .i1(i1[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .o(o[1]), .cout(cout[1]), .zero(zero[1]), .neg(neg[1]), .ovf(ovf[1]));
    alu_serial #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .reset(reset[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op(op[2]), .i0(i0[2]), .i1(i1[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .o(o[2]), .cout(cout[2]), .zero(zero[2]), .neg(neg[2]), .ovf(ovf[2]));

    // Reference: {cout, zero, neg, ovf, o} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (opc)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {c, (r == 16'h0), r[15], v, r};
    endfunction

    task automatic issue(input int k, input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        while (!in_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!in_ready[k]) begin
            bad++;
            $display("FAIL issue_ready[%0d]: in_ready=%b want 1", k, in_ready[k]);
        end
        op[k] = opc; i0[k] = a; i1[k] = b; in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        i0[k] = 16'($urandom);
        i1[k] = 16'($urandom);
        op[k] = 2'($urandom);
    endtask

    // Issue one op, leave the DUT in DONE, check latency and result.
    task automatic run_op(input int k, input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b,
                          input string tag);
        int cyc;
        logic [19:0] e;
        issue(k, opc, a, b);
        cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        e = model(opc, a, b);
        total++;
        if (cyc !== LAT[k] || out_valid[k] !== 1'b1) begin
            bad++;
            $display("FAIL %s latency[%0d]: got %0d cycles valid=%b want %0d", tag, k, cyc, out_valid[k], LAT[k]);
        end
        total++;
        if (o[k] !== e[15:0]) begin
            bad++;
            $display("FAIL %s o[%0d] op=%0d a=%h b=%h: got %h want %h", tag, k, opc, a, b, o[k], e[15:0]);
        end
        total++;
        if ({cout[k], zero[k], neg[k], ovf[k]} !== e[19:16]) begin
            bad++;
            $display("FAIL %s flags[%0d] op=%0d a=%h b=%h: got czno=%b want %b", tag, k, opc, a, b,
                     {cout[k], zero[k], neg[k], ovf[k]}, e[19:16]);
        end
    endtask

    task automatic release_op(input int k, input logic [15:0] exp_o, input string tag);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        total++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || o[k] !== exp_o) begin
            bad++;
            $display("FAIL %s release[%0d]: in_ready=%b out_valid=%b o=%h want 1 0 %h", tag, k,
                     in_ready[k], out_valid[k], o[k], exp_o);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            op[k] = 2'b00; i0[k] = 16'h0; i1[k] = 16'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || o[k] !== 16'h0 ||
                {cout[k], zero[k], neg[k], ovf[k]} !== 4'b0000) begin
                bad++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b o=%h czno=%b want 1 0 0000 0000", k,
                         in_ready[k], out_valid[k], o[k], {cout[k], zero[k], neg[k], ovf[k]});
            end
        end
    endtask

    task automatic test_directed;
        run_op(0, 2'b00, 16'h7FFF, 16'h0001, "add_ovf");   release_op(0, 16'h8000, "add_ovf");
        run_op(0, 2'b00, 16'hFFFF, 16'h0001, "add_wrap");  release_op(0, 16'h0000, "add_wrap");
        run_op(0, 2'b01, 16'h0005, 16'h0005, "sub_zero");  release_op(0, 16'h0000, "sub_zero");
        run_op(0, 2'b01, 16'h0003, 16'h0005, "sub_neg");   release_op(0, 16'hFFFE, "sub_neg");
        run_op(0, 2'b01, 16'h8000, 16'h0001, "sub_ovf");   release_op(0, 16'h7FFF, "sub_ovf");
        run_op(0, 2'b10, 16'hF0F0, 16'h3C3C, "and");       release_op(0, 16'h3030, "and");
        run_op(0, 2'b11, 16'hF0F0, 16'h3C3C, "or");        release_op(0, 16'hFCFC, "or");
    endtask

    task automatic test_backpressure;
        logic [15:0] held;
        run_op(0, 2'b00, 16'h1234, 16'h4321, "bp");
        held = o[0];
        in_valid[0] = 1'b1; op[0] = 2'b11; i0[0] = 16'hAAAA; i1[0] = 16'h5555;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || o[0] !== 16'h5555 ||
                {cout[0], zero[0], neg[0], ovf[0]} !== 4'b0000) begin
                bad++;
                $display("FAIL backpressure cycle %0d: vld=%b rdy=%b o=%h czno=%b want 1 0 5555 0000", c,
                         out_valid[0], in_ready[0], o[0], {cout[0], zero[0], neg[0], ovf[0]});
            end
        end
        // in_valid stays high through the handshake edge; it must not be accepted there.
        release_op(0, held, "bp");
        in_valid[0] = 1'b0;
    endtask

    task automatic test_reset_midrun(input int k);
        run_op(k, 2'b00, 16'h1111, 16'h2222, "pre_rst");
        release_op(k, 16'h3333, "pre_rst");
        op[k] = 2'b01; i0[k] = 16'h0001; i1[k] = 16'h0002; in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset[k] = 1'b0;
        total++;
        if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || o[k] !== 16'h0 ||
            {cout[k], zero[k], neg[k], ovf[k]} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_midrun[%0d]: rdy=%b vld=%b o=%h czno=%b want 1 0 0000 0000", k,
                     in_ready[k], out_valid[k], o[k], {cout[k], zero[k], neg[k], ovf[k]});
        end
        run_op(k, 2'b01, 16'h0010, 16'h0001, "post_rst");
        release_op(k, 16'h000F, "post_rst");
    endtask

    task automatic test_random(input int k, input int count);
        logic [1:0]  r_op;
        logic [15:0] r_a, r_b;
        logic [19:0] e;
        for (int n = 0; n < count; n++) begin
            r_op = 2'($urandom_range(3));
            r_a  = 16'($urandom);
            r_b  = (n % 5 == 0) ? r_a : 16'($urandom);
            e    = model(r_op, r_a, r_b);
            run_op(k, r_op, r_a, r_b, "rand");
            release_op(k, e[15:0], "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        for (int k = 0; k < 3; k++) test_reset_midrun(k);
        run_op(1, 2'b00, 16'h7FFF, 16'h0001, "add_ovf16"); release_op(1, 16'h8000, "add_ovf16");
        run_op(2, 2'b01, 16'h8000, 16'h0001, "sub_ovf1");  release_op(2, 16'h7FFF, "sub_ovf1");
        for (int k = 0; k < 3; k++) test_random(k, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
